// File: rtl/ctc_is_sequencer_if.sv
// ARC serial instruction bus, sequencer side: ROM fetch, branch/pointer requests,
// carry return, and the is/sync/ws serial outputs.
interface ctc_is_sequencer_if #(
  parameter int ADR_W = 8
);
  logic [ADR_W-1:0] rom_adr;
  logic [9:0]       rom_data;
  logic             adr_ld;
  logic [ADR_W-1:0] adr_in;
  logic             ptr_ld;
  logic [3:0]       ptr_in;
  logic             carry_in;
  logic [5:0]       bit_cnt;
  logic             sync;
  logic             is;
  logic             ws;
  logic [3:0]       ptr;
  logic             carry_flag;

  modport master (
    output rom_adr, bit_cnt, sync, is, ws, ptr, carry_flag,
    input  rom_data, adr_ld, adr_in, ptr_ld, ptr_in, carry_in
  );

  modport slave (
    input  rom_adr, bit_cnt, sync, is, ws, ptr, carry_flag,
    output rom_data, adr_ld, adr_in, ptr_ld, ptr_in, carry_in
  );
endinterface

// File: rtl/ctc_is_sequencer.sv
// ARC instruction sequencer: 56-bit-time word counter, ROM stepping, is/sync serialiser and ws decode.
// Branch and pointer loads are held pending and take effect only at the word boundary.
module ctc_is_sequencer #(
  parameter int ADR_W      = 8,
  parameter int PTR_RST    = 3,
  parameter int SYNC_FIRST = 45
) (
  input logic               cph2,
  input logic               rstn,
  ctc_is_sequencer_if.master bus
);

  localparam logic [5:0] C_LAST_BIT = 6'd55;
  localparam logic [5:0] C_SYNC_LO  = 6'(SYNC_FIRST);
  localparam logic [5:0] C_SYNC_HI  = 6'(SYNC_FIRST + 9);
  localparam logic [5:0] C_LATCH    = 6'(SYNC_FIRST - 1);

  localparam logic [2:0] FT_P  = 3'b000;
  localparam logic [2:0] FT_M  = 3'b001;
  localparam logic [2:0] FT_X  = 3'b010;
  localparam logic [2:0] FT_W  = 3'b011;
  localparam logic [2:0] FT_WP = 3'b100;
  localparam logic [2:0] FT_MS = 3'b101;
  localparam logic [2:0] FT_XS = 3'b110;

  logic [5:0]       r_bit_cnt;
  logic [ADR_W-1:0] r_rom_adr;
  logic [9:0]       r_instr;
  logic             r_field_en;
  logic [2:0]       r_field_type;
  logic [3:0]       r_ptr;
  logic             r_pend_adr_vld;
  logic [ADR_W-1:0] r_pend_adr;
  logic             r_pend_ptr_vld;
  logic [3:0]       r_pend_ptr;
  logic             r_carry_acc;
  logic             r_carry_flag;

  logic             w_wrap;
  logic [3:0]       w_digit;
  logic             w_sync;
  logic             w_is;
  logic             w_ws;
  logic             w_carry_now;

  assign w_wrap      = (r_bit_cnt == C_LAST_BIT);
  assign w_digit     = r_bit_cnt[5:2];
  assign w_sync      = (r_bit_cnt >= C_SYNC_LO) && (r_bit_cnt <= C_SYNC_HI);
  assign w_carry_now = bus.carry_in & w_ws;

  always_comb begin
    w_is = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (w_sync && (r_bit_cnt == C_SYNC_LO + 6'(k))) begin
        w_is = r_instr[k];
      end
    end
  end

  always_comb begin
    w_ws = 1'b1;
    if (r_field_en) begin
      case (r_field_type)
        FT_P:    w_ws = (w_digit == r_ptr);
        FT_M:    w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd12);
        FT_X:    w_ws = (w_digit <= 4'd2);
        FT_W:    w_ws = 1'b1;
        FT_WP:   w_ws = (w_digit <= r_ptr);
        FT_MS:   w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd13);
        FT_XS:   w_ws = (w_digit == 4'd2);
        default: w_ws = (w_digit == 4'd13);
      endcase
    end
  end

  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt <= '0;
    end else if (w_wrap) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end
  end

  // A request arriving on the boundary cycle itself re-arms the pending slot for the next word.
  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      r_rom_adr      <= '0;
      r_pend_adr_vld <= 1'b0;
      r_pend_adr     <= '0;
      r_ptr          <= 4'(PTR_RST);
      r_pend_ptr_vld <= 1'b0;
      r_pend_ptr     <= '0;
    end else begin
      if (w_wrap) begin
        r_rom_adr      <= r_pend_adr_vld ? r_pend_adr : r_rom_adr + {{(ADR_W-1){1'b0}}, 1'b1};
        r_pend_adr_vld <= bus.adr_ld;
        if (r_pend_ptr_vld) begin
          r_ptr <= r_pend_ptr;
        end
        r_pend_ptr_vld <= bus.ptr_ld;
      end else begin
        if (bus.adr_ld) begin
          r_pend_adr_vld <= 1'b1;
        end
        if (bus.ptr_ld) begin
          r_pend_ptr_vld <= 1'b1;
        end
      end
      if (bus.adr_ld) begin
        r_pend_adr <= bus.adr_in;
      end
      if (bus.ptr_ld) begin
        r_pend_ptr <= bus.ptr_in;
      end
    end
  end

  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      r_instr      <= '0;
      r_field_en   <= 1'b0;
      r_field_type <= '0;
    end else begin
      if (r_bit_cnt == C_LATCH) begin
        r_instr <= bus.rom_data;
      end
      if (w_wrap) begin
        r_field_type <= r_instr[4:2];
        r_field_en   <= (r_instr[1:0] == 2'b10);
      end
    end
  end

  always_ff @(posedge cph2 or negedge rstn) begin
    if (!rstn) begin
      r_carry_acc  <= 1'b0;
      r_carry_flag <= 1'b0;
    end else if (w_wrap) begin
      r_carry_flag <= r_carry_acc | w_carry_now;
      r_carry_acc  <= 1'b0;
    end else begin
      r_carry_acc  <= r_carry_acc | w_carry_now;
    end
  end

  assign bus.rom_adr    = r_rom_adr;
  assign bus.bit_cnt    = r_bit_cnt;
  assign bus.sync       = w_sync;
  assign bus.is         = w_is;
  assign bus.ws         = w_ws;
  assign bus.ptr        = r_ptr;
  assign bus.carry_flag = r_carry_flag;

endmodule

// File: tb/tb_ctc_is_sequencer.sv
// Randomised scoreboard bench for ctc_is_sequencer against a word-level reference model.
module tb_ctc_is_sequencer;

  typedef struct packed {
    logic [5:0] bc;
    logic [7:0] adr;
    logic       sync;
    logic       is_;
    logic       ws;
    logic [3:0] ptr;
    logic       cf;
  } obs_t;

  logic cph2;
  logic rstn;
  logic [9:0] rom [0:255];

  ctc_is_sequencer_if #(.ADR_W(8)) bus ();

  ctc_is_sequencer #(.ADR_W(8), .PTR_RST(3), .SYNC_FIRST(45)) dut (
    .cph2 (cph2),
    .rstn (rstn),
    .bus  (bus)
  );

  assign bus.rom_data = rom[bus.rom_adr];

  initial cph2 = 1'b0;
  always #5 cph2 = ~cph2;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;
  obs_t sb [$];

  // Reference model state, kept as plain integers.
  int   m_cnt, m_adr, m_ptr, m_pa, m_pp, m_ftype;
  bit   m_pa_v, m_pp_v, m_fen, m_acc, m_cf;
  logic [9:0] m_instr;

  function automatic bit ref_ws(int cnt, bit fen, int ft, int p);
    int d;
    d = cnt / 4;
    if (!fen) return 1'b1;
    case (ft)
      0: return d == p;
      1: return d >= 3 && d <= 12;
      2: return d <= 2;
      3: return 1'b1;
      4: return d <= p;
      5: return d >= 3 && d <= 13;
      6: return d == 2;
      default: return d == 13;
    endcase
  endfunction

  function automatic obs_t ref_obs();
    obs_t o;
    o.bc   = 6'(m_cnt);
    o.adr  = 8'(m_adr);
    o.sync = (m_cnt >= 45 && m_cnt <= 54);
    o.is_  = o.sync ? m_instr[m_cnt - 45] : 1'b0;
    o.ws   = ref_ws(m_cnt, m_fen, m_ftype, m_ptr);
    o.ptr  = 4'(m_ptr);
    o.cf   = m_cf;
    return o;
  endfunction

  always @(posedge cph2 or negedge rstn) begin
    bit w, c;
    if (!rstn) begin
      m_cnt = 0; m_adr = 0; m_instr = '0; m_fen = 0; m_ftype = 0;
      m_ptr = 3; m_pa_v = 0; m_pp_v = 0; m_pa = 0; m_pp = 0; m_acc = 0; m_cf = 0;
      sb.delete();
    end else begin
      w = ref_ws(m_cnt, m_fen, m_ftype, m_ptr);
      c = bus.carry_in & w;
      if (m_cnt == 55) begin
        m_adr = m_pa_v ? m_pa : (m_adr + 1) % 256;
        m_ptr = m_pp_v ? m_pp : m_ptr;
        m_pa_v = bus.adr_ld;
        m_pp_v = bus.ptr_ld;
        m_fen = (m_instr[1:0] == 2'b10);
        m_ftype = int'(m_instr[4:2]);
        m_cf = m_acc | c;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        if (bus.adr_ld) m_pa_v = 1;
        if (bus.ptr_ld) m_pp_v = 1;
        m_acc = m_acc | c;
        if (m_cnt == 44) m_instr = rom[m_adr];
        m_cnt = m_cnt + 1;
      end
      if (bus.adr_ld) m_pa = int'(bus.adr_in);
      if (bus.ptr_ld) m_pp = int'(bus.ptr_in);
    end
    sb.push_back(ref_obs());
  end

  always @(negedge cph2) begin
    obs_t exp_o, got;
    if (sb.size() > 2) begin
      failures++;
      $display("FAIL sb_depth got=%0d required<=2", sb.size());
      sb.delete();
    end
    if (sb.size() == 0) begin
      if (started && rstn) begin
        checks++;
        failures++;
        $display("FAIL sb_empty no expectation queued at t=%0t", $time);
      end
    end else begin
      exp_o = sb.pop_front();
      got.bc   = bus.bit_cnt;
      got.adr  = bus.rom_adr;
      got.sync = bus.sync;
      got.is_  = bus.is;
      got.ws   = bus.ws;
      got.ptr  = bus.ptr;
      got.cf   = bus.carry_flag;
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL cycle_obs t=%0t got bc=%0d adr=%02h sync=%b is=%b ws=%b ptr=%0d cf=%b required bc=%0d adr=%02h sync=%b is=%b ws=%b ptr=%0d cf=%b",
                 $time, got.bc, got.adr, got.sync, got.is_, got.ws, got.ptr, got.cf,
                 exp_o.bc, exp_o.adr, exp_o.sync, exp_o.is_, exp_o.ws, exp_o.ptr, exp_o.cf);
      end
    end
  end

  task automatic tick();
    @(posedge cph2);
    #2;
  endtask

  task automatic idle_inputs();
    bus.adr_ld = 1'b0; bus.adr_in = '0;
    bus.ptr_ld = 1'b0; bus.ptr_in = '0;
    bus.carry_in = 1'b0;
  endtask

  task automatic drive_rand(int p_adr, int p_ptr);
    bus.adr_ld   = ($urandom_range(0, 99) < p_adr);
    bus.adr_in   = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
    bus.ptr_ld   = ($urandom_range(0, 99) < p_ptr);
    bus.ptr_in   = 4'($urandom);
    bus.carry_in = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_cnt(int target);
    for (int n = 0; n < 60 && m_cnt != target; n++) tick();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) rom[i] = 10'b11101_010_00;
    repeat (3) tick();
    rstn = 1'b1;
    started = 1;
    repeat (2 * 56) tick();

    // Field sweep: eight field instructions at 0x10.., pointer left at reset value.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 10'($urandom);
      if ($urandom_range(0, 2) != 0) rom[i][1:0] = 2'b10;
    end
    for (int k = 0; k < 8; k++) rom[16 + k] = {5'b11111, 3'(k), 2'b10};
    wait_cnt(10);
    bus.adr_ld = 1'b1; bus.adr_in = 8'h10;
    tick();
    bus.adr_ld = 1'b0;
    for (int n = 0; n < 10 * 56; n++) begin
      tick();
      bus.carry_in = ($urandom_range(0, 7) == 0);
    end

    for (int n = 0; n < 40 * 56; n++) begin
      tick();
      drive_rand(2, 3);
    end
    idle_inputs();

    wait_cnt(48);
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    for (int n = 0; n < 3 * 56; n++) begin
      tick();
      drive_rand(2, 3);
    end

    wait_cnt($urandom_range(1, 54));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int n = 0; n < 4 * 56; n++) begin
      tick();
      drive_rand(3, 3);
    end
    idle_inputs();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
